// File: rtl/cpu_pkg.sv
// Shared CPU constants: forward-select codes, ALU opcode width, link register number.
package cpu_pkg;

    localparam int ALUC_W = 4;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_MEM = 2'd1;
    localparam logic [1:0] FWD_WB  = 2'd2;

    // jal writes its link address to r31; the destination mux lives upstream in ID.
    localparam logic [4:0] REG_RA = 5'd31;

endpackage

// File: rtl/fwd_mux.sv
// Forwarding operand select; combinational, no flow control.
// The reserved code 2'b11 falls back to the register-file value.
module fwd_mux
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32
)(
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] rf,
    input  logic [WIDTH-1:0] mem,
    input  logic [WIDTH-1:0] wb,
    output logic [WIDTH-1:0] q
);

    always_comb begin
        q = rf;
        case (sel)
            FWD_MEM: q = mem;
            FWD_WB:  q = wb;
            default: q = rf;
        endcase
    end

endmodule

// File: rtl/pipe_idexe.sv
// ID/EXE register and EXE operand stage; outputs appear one cycle after capture, operands combinational.
// No handshake: stall holds every register, bubble loads a NOP. Forwarding muxes exist only under PIPE_FWD_EN.
module pipe_idexe
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int RNW   = 5
)(
    input  logic              clk,
    input  logic              clrn,
    input  logic              stall,
    input  logic              bubble,
    input  logic              d_wreg,
    input  logic              d_m2reg,
    input  logic              d_wmem,
    input  logic              d_aluimm,
    input  logic              d_shift,
    input  logic              d_jal,
    input  logic [ALUC_W-1:0] d_aluc,
    input  logic [RNW-1:0]    d_rn,
    input  logic [WIDTH-1:0]  d_qa,
    input  logic [WIDTH-1:0]  d_qb,
    input  logic [WIDTH-1:0]  d_imm,
    input  logic [WIDTH-1:0]  d_pc4,
    input  logic [1:0]        d_fwda,
    input  logic [1:0]        d_fwdb,
    input  logic [WIDTH-1:0]  m_alu,
    input  logic [WIDTH-1:0]  w_data,
    output logic [WIDTH-1:0]  e_a,
    output logic [WIDTH-1:0]  e_b,
    output logic [ALUC_W-1:0] e_aluc,
    output logic              e_wreg,
    output logic              e_m2reg,
    output logic              e_wmem,
    output logic              e_jal,
    output logic [RNW-1:0]    e_rn,
    output logic [WIDTH-1:0]  e_sdata,
    output logic [WIDTH-1:0]  e_pc8
);

    logic              wreg, m2reg, wmem, aluimm, shift, jal;
    logic [ALUC_W-1:0] aluc;
    logic [RNW-1:0]    rn;
    logic [WIDTH-1:0]  qa, qb, imm, pc4;
    logic [WIDTH-1:0]  fa, fb;

    // A bubble zeroes every field, so a killed slot looks exactly like the reset state.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wreg   <= 1'b0;
            m2reg  <= 1'b0;
            wmem   <= 1'b0;
            aluimm <= 1'b0;
            shift  <= 1'b0;
            jal    <= 1'b0;
            aluc   <= '0;
            rn     <= '0;
            qa     <= '0;
            qb     <= '0;
            imm    <= '0;
            pc4    <= '0;
        end else if (!stall) begin
            wreg   <= d_wreg   & ~bubble;
            m2reg  <= d_m2reg  & ~bubble;
            wmem   <= d_wmem   & ~bubble;
            aluimm <= d_aluimm & ~bubble;
            shift  <= d_shift  & ~bubble;
            jal    <= d_jal    & ~bubble;
            aluc   <= bubble ? '0 : d_aluc;
            rn     <= bubble ? '0 : d_rn;
            qa     <= bubble ? '0 : d_qa;
            qb     <= bubble ? '0 : d_qb;
            imm    <= bubble ? '0 : d_imm;
            pc4    <= bubble ? '0 : d_pc4;
        end
    end

`ifdef PIPE_FWD_EN
    logic [1:0] fwda, fwdb;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            fwda <= FWD_RF;
            fwdb <= FWD_RF;
        end else if (!stall) begin
            fwda <= bubble ? FWD_RF : d_fwda;
            fwdb <= bubble ? FWD_RF : d_fwdb;
        end
    end

    fwd_mux #(.WIDTH(WIDTH)) u_fwd_a (.sel(fwda), .rf(qa), .mem(m_alu), .wb(w_data), .q(fa));
    fwd_mux #(.WIDTH(WIDTH)) u_fwd_b (.sel(fwdb), .rf(qb), .mem(m_alu), .wb(w_data), .q(fb));
`else
    // Without forwarding the hazard unit stalls on every RAW, so these inputs carry nothing useful.
    logic unused_fwd;
    assign unused_fwd = ^{d_fwda, d_fwdb, m_alu, w_data};
    assign fa = qa;
    assign fb = qb;
`endif

    assign e_a     = shift  ? {{(WIDTH-5){1'b0}}, imm[10:6]} : fa;
    assign e_b     = aluimm ? imm : fb;
    assign e_sdata = fb;
    assign e_pc8   = pc4 + WIDTH'(4);
    assign e_aluc  = aluc;
    assign e_wreg  = wreg;
    assign e_m2reg = m2reg;
    assign e_wmem  = wmem;
    assign e_jal   = jal;
    assign e_rn    = rn;

endmodule
